// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable prescaled down-counter with one-shot/periodic expiry.
// Revision : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  tick,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic [WIDTH-1:0]      r_reload;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_running;
    logic                  r_tick;
    logic                  r_done;

    state_t                w_state;
    logic [WIDTH-1:0]      w_count;
    logic [WIDTH-1:0]      w_reload;
    logic [PRESCALE_W-1:0] w_presc;
    logic                  w_tick;
    logic                  w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_reload  <= w_reload;
            r_presc   <= w_presc;
            r_running <= (w_state == S_RUN);
            r_tick    <= w_tick;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_reload = r_reload;
        w_presc  = r_presc;
        w_tick   = 1'b0;
        w_done   = r_done;

        if (ld) begin
            w_count  = data;
            w_reload = data;
            w_presc  = '0;
            w_state  = S_IDLE;
            w_done   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stop && start) begin
                        if (r_count != '0) begin
                            w_state = S_RUN;
                            w_presc = '0;
                        end else begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                            w_tick  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_state = S_IDLE;
                        w_presc = '0;
                    end else if (r_presc == prescale) begin
                        w_presc = '0;
                        if (r_count > WIDTH'(1)) begin
                            w_count = r_count - WIDTH'(1);
                        end else begin
                            // Terminal step: auto_reload is only consulted here
                            w_tick = 1'b1;
                            if (auto_reload) begin
                                w_count = r_reload;
                            end else begin
                                w_count = '0;
                                w_state = S_DONE;
                                w_done  = 1'b1;
                            end
                        end
                    end else begin
                        w_presc = r_presc + PRESCALE_W'(1);
                    end
                end
                S_DONE: begin
                    if (!stop && start) begin
                        if (r_reload != '0) begin
                            w_count = r_reload;
                            w_done  = 1'b0;
                            w_state = S_RUN;
                            w_presc = '0;
                        end else begin
                            w_tick = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign tick    = r_tick;
    assign done    = r_done;

endmodule
`default_nettype wire
